// File: rtl/rv_pkg.sv
// Shared RV32IM pipeline definitions used by the fetch stage and its IF/ID register.
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FLUSH = 2'd1,
        IFID_LOAD  = 2'd2
    } ifid_op_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID bundle of the fetch stage.
// slave = fetch stage side, master = surrounding pipeline / memory side.
interface fetch_if;
    import rv_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pc4;
    logic [XLEN-1:0] ifid_instr;
    logic            ifid_valid;
    logic            fetch_misalign;
    logic            halted;
    logic [31:0]     fetch_count;

    modport master (
        output stall, redirect, redirect_pc, halt, imem_instr,
        input  imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
               fetch_misalign, halted, fetch_count
    );

    modport slave (
        input  stall, redirect, redirect_pc, halt, imem_instr,
        output imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
               fetch_misalign, halted, fetch_count
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold, flush to a NOP bubble, or load a new fetch.
module ifid_reg
    import rv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  ifid_op_e        op_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // A flush leaves the PC fields alone; only the instruction/valid pair becomes a bubble.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (op_i)
            IFID_LOAD: begin
                pc_d    = pc_i;
                pc4_d   = pc_i + 32'd4;
                instr_d = instr_i;
                valid_d = 1'b1;
            end
            IFID_FLUSH: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            IFID_HOLD: begin
                valid_d = valid_q;
            end
            default: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase
    end

    // IF/ID state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32IM instruction-fetch stage: PC, BOOT/RUN/HALT sequencing, IF/ID register
// and a retired-fetch counter for bring-up.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic  clk_i,
    input  logic  rst_i,
    fetch_if.slave fif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            misalign_q, misalign_d;
    ifid_op_e        ifid_op_s;

    // Next-state: REDIRECT beats HALT beats STALL beats sequential fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        ifid_op_s  = IFID_HOLD;
        case (state_q)
            FS_BOOT: begin
                state_d   = FS_RUN;
                pc_d      = RESET_PC_P;
                ifid_op_s = IFID_FLUSH;
            end
            FS_RUN: begin
                if (fif.redirect) begin
                    pc_d       = {fif.redirect_pc[XLEN-1:2], 2'b00};
                    misalign_d = is_misaligned(fif.redirect_pc);
                    ifid_op_s  = IFID_FLUSH;
                end else if (fif.halt) begin
                    state_d   = FS_HALT;
                    ifid_op_s = IFID_FLUSH;
                end else if (fif.stall) begin
                    ifid_op_s = IFID_HOLD;
                end else begin
                    ifid_op_s = IFID_LOAD;
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + 32'd1;
                end
            end
            FS_HALT: begin
                ifid_op_s = IFID_FLUSH;
            end
            default: begin
                state_d   = FS_BOOT;
                ifid_op_s = IFID_FLUSH;
            end
        endcase
    end

    // PC, FSM, misalign flag and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FS_BOOT;
            pc_q       <= RESET_PC_P;
            count_q    <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (ifid_op_s),
        .pc_i    (pc_q),
        .instr_i (fif.imem_instr),
        .pc_o    (fif.ifid_pc),
        .pc4_o   (fif.ifid_pc4),
        .instr_o (fif.ifid_instr),
        .valid_o (fif.ifid_valid)
    );

    assign fif.imem_addr      = pc_q;
    assign fif.halted         = (state_q == FS_HALT);
    assign fif.fetch_misalign = misalign_q;
    assign fif.fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model queues expected IF/ID
// entries as fetches are stimulated; scenario tasks pop and compare them.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    fetch_if fif ();

    fetch_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
    endfunction

    assign fif.imem_instr = imem_fn(fif.imem_addr);

    int n_pass  = 0;
    int n_total = 0;

    // model state
    typedef enum int {M_BOOT, M_RUN, M_HALT} mstate_e;
    mstate_e     m_state;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_mis;
    logic [31:0] m_ifid_pc;
    logic [95:0] sb_q[$];
    logic [95:0] exp_e;

    // Drive one cycle, advance the model, queue an expected IF/ID entry on a fetch.
    task automatic cycle(input logic r, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic hl, output logic loaded);
        rst             = r;
        fif.stall       = st;
        fif.redirect    = rd;
        fif.redirect_pc = rpc;
        fif.halt        = hl;
        loaded          = 1'b0;
        m_mis           = 1'b0;
        if (r) begin
            m_state   = M_BOOT;
            m_pc      = 32'h0;
            m_count   = 32'h0;
            m_ifid_pc = 32'h0;
            sb_q.delete();
        end else if (m_state == M_BOOT) begin
            m_state = M_RUN;
            m_pc    = 32'h0;
        end else if (m_state == M_RUN) begin
            if (rd) begin
                m_pc  = {rpc[31:2], 2'b00};
                m_mis = (rpc[1:0] != 2'b00);
            end else if (hl) begin
                m_state = M_HALT;
            end else if (!st) begin
                sb_q.push_back({m_pc, m_pc + 32'd4, imem_fn(m_pc)});
                m_ifid_pc = m_pc;
                m_pc      = m_pc + 32'd4;
                m_count   = m_count + 32'd1;
                loaded    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic ld;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, ld);
        n_total++; if (fif.imem_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=%h", fif.imem_addr, 32'h0); else n_pass++;
        n_total++; if (fif.ifid_pc !== 32'h0) $display("FAIL reset_ifid_pc got=%h exp=%h", fif.ifid_pc, 32'h0); else n_pass++;
        n_total++; if (fif.ifid_pc4 !== 32'h0) $display("FAIL reset_ifid_pc4 got=%h exp=%h", fif.ifid_pc4, 32'h0); else n_pass++;
        n_total++; if (fif.ifid_instr !== NOP) $display("FAIL reset_instr got=%h exp=%h", fif.ifid_instr, NOP); else n_pass++;
        n_total++; if (fif.ifid_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fif.ifid_valid); else n_pass++;
        n_total++; if (fif.fetch_misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", fif.fetch_misalign); else n_pass++;
        n_total++; if (fif.halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", fif.halted); else n_pass++;
        n_total++; if (fif.fetch_count !== 32'h0) $display("FAIL reset_count got=%0d exp=0", fif.fetch_count); else n_pass++;
    endtask

    task automatic test_run();
        logic ld;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        n_total++; if (fif.imem_addr !== 32'h0) $display("FAIL boot_addr got=%h exp=%h", fif.imem_addr, 32'h0); else n_pass++;
        n_total++; if (fif.ifid_valid !== 1'b0) $display("FAIL boot_valid got=%b exp=0", fif.ifid_valid); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
            exp_e = sb_q.pop_front();
            n_total++; if ({fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr} !== exp_e) $display("FAIL run_ifid got=%h exp=%h", {fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr}, exp_e); else n_pass++;
            n_total++; if (fif.ifid_valid !== 1'b1) $display("FAIL run_valid got=%b exp=1", fif.ifid_valid); else n_pass++;
            n_total++; if (fif.imem_addr !== 32'(4 * (i + 1))) $display("FAIL run_addr got=%h exp=%h", fif.imem_addr, 32'(4 * (i + 1))); else n_pass++;
        end
        n_total++; if (fif.fetch_count !== 32'd2) $display("FAIL run_count got=%0d exp=2", fif.fetch_count); else n_pass++;
    endtask

    task automatic test_stall();
        logic ld;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, ld);
            n_total++; if (fif.imem_addr !== 32'h8) $display("FAIL stall_addr got=%h exp=%h", fif.imem_addr, 32'h8); else n_pass++;
            n_total++; if (fif.ifid_pc !== 32'h4 || fif.ifid_valid !== 1'b1) $display("FAIL stall_ifid got=%h/%b exp=%h/1", fif.ifid_pc, fif.ifid_valid, 32'h4); else n_pass++;
            n_total++; if (fif.fetch_count !== 32'd2) $display("FAIL stall_count got=%0d exp=2", fif.fetch_count); else n_pass++;
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        exp_e = sb_q.pop_front();
        n_total++; if ({fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr} !== exp_e) $display("FAIL stall_resume got=%h exp=%h", {fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr}, exp_e); else n_pass++;
        n_total++; if (fif.ifid_pc !== 32'h8) $display("FAIL stall_resume_pc got=%h exp=%h", fif.ifid_pc, 32'h8); else n_pass++;
    endtask

    task automatic test_redirect(input logic [31:0] target);
        logic ld;
        logic [31:0] aligned;
        aligned = {target[31:2], 2'b00};
        cycle(1'b0, 1'b1, 1'b1, target, 1'b0, ld);
        n_total++; if (fif.imem_addr !== aligned) $display("FAIL redir_addr got=%h exp=%h", fif.imem_addr, aligned); else n_pass++;
        n_total++; if (fif.ifid_instr !== NOP || fif.ifid_valid !== 1'b0) $display("FAIL redir_bubble got=%h/%b exp=%h/0", fif.ifid_instr, fif.ifid_valid, NOP); else n_pass++;
        n_total++; if (fif.fetch_misalign !== m_mis) $display("FAIL redir_misalign got=%b exp=%b", fif.fetch_misalign, m_mis); else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        exp_e = sb_q.pop_front();
        n_total++; if ({fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr} !== exp_e) $display("FAIL redir_target got=%h exp=%h", {fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr}, exp_e); else n_pass++;
        n_total++; if (fif.ifid_pc !== aligned || fif.ifid_valid !== 1'b1) $display("FAIL redir_target_pc got=%h/%b exp=%h/1", fif.ifid_pc, fif.ifid_valid, aligned); else n_pass++;
        n_total++; if (fif.fetch_misalign !== 1'b0) $display("FAIL misalign_pulse got=%b exp=0", fif.fetch_misalign); else n_pass++;
    endtask

    task automatic test_wrap();
        logic ld;
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, ld);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        exp_e = sb_q.pop_front();
        n_total++; if ({fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr} !== exp_e) $display("FAIL wrap_ifid got=%h exp=%h", {fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr}, exp_e); else n_pass++;
        n_total++; if (fif.ifid_pc4 !== 32'h0) $display("FAIL wrap_pc4 got=%h exp=%h", fif.ifid_pc4, 32'h0); else n_pass++;
        n_total++; if (fif.imem_addr !== 32'h0) $display("FAIL wrap_addr got=%h exp=%h", fif.imem_addr, 32'h0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ld;
        logic st, rd;
        logic [31:0] rpc;
        for (int i = 0; i < 40; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom();
            cycle(1'b0, st, rd, rpc, 1'b0, ld);
            if (ld) begin
                exp_e = sb_q.pop_front();
                n_total++; if ({fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr} !== exp_e || fif.ifid_valid !== 1'b1) $display("FAIL b2b_ifid got=%h/%b exp=%h/1", {fif.ifid_pc, fif.ifid_pc4, fif.ifid_instr}, fif.ifid_valid, exp_e); else n_pass++;
            end else begin
                n_total++; if (fif.ifid_pc !== m_ifid_pc) $display("FAIL b2b_hold_pc got=%h exp=%h", fif.ifid_pc, m_ifid_pc); else n_pass++;
            end
            n_total++; if (fif.imem_addr !== m_pc) $display("FAIL b2b_addr got=%h exp=%h", fif.imem_addr, m_pc); else n_pass++;
            n_total++; if (fif.fetch_count !== m_count) $display("FAIL b2b_count got=%0d exp=%0d", fif.fetch_count, m_count); else n_pass++;
            n_total++; if (fif.fetch_misalign !== m_mis) $display("FAIL b2b_misalign got=%b exp=%b", fif.fetch_misalign, m_mis); else n_pass++;
        end
        n_total++; if (sb_q.size() !== 0) $display("FAIL b2b_sb_left got=%0d exp=0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_halt();
        logic ld;
        logic [31:0] cnt;
        cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, ld);
        cnt = m_count;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ld);
        n_total++; if (fif.halted !== 1'b1) $display("FAIL halt_flag got=%b exp=1", fif.halted); else n_pass++;
        n_total++; if (fif.imem_addr !== 32'h10) $display("FAIL halt_addr got=%h exp=%h", fif.imem_addr, 32'h10); else n_pass++;
        n_total++; if (fif.ifid_instr !== NOP || fif.ifid_valid !== 1'b0) $display("FAIL halt_bubble got=%h/%b exp=%h/0", fif.ifid_instr, fif.ifid_valid, NOP); else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, ld);
        n_total++; if (fif.imem_addr !== 32'h10 || fif.halted !== 1'b1) $display("FAIL halt_redir_ignored got=%h/%b exp=%h/1", fif.imem_addr, fif.halted, 32'h10); else n_pass++;
        n_total++; if (fif.fetch_count !== cnt) $display("FAIL halt_count got=%0d exp=%0d", fif.fetch_count, cnt); else n_pass++;
        cycle(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, ld);
        n_total++; if (fif.imem_addr !== 32'h0 || fif.halted !== 1'b0) $display("FAIL halt_reset got=%h/%b exp=%h/0", fif.imem_addr, fif.halted, 32'h0); else n_pass++;
        n_total++; if (fif.fetch_count !== 32'h0) $display("FAIL halt_reset_count got=%0d exp=0", fif.fetch_count); else n_pass++;
    endtask

    task automatic test_reset_overrides();
        logic ld;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ld);
        cycle(1'b1, 1'b0, 1'b1, 32'h42, 1'b0, ld);
        n_total++; if (fif.imem_addr !== 32'h0 || fif.ifid_valid !== 1'b0 || fif.fetch_misalign !== 1'b0) $display("FAIL midreset got=%h/%b/%b exp=%h/0/0", fif.imem_addr, fif.ifid_valid, fif.fetch_misalign, 32'h0); else n_pass++;
        n_total++; if (fif.ifid_pc !== 32'h0 || fif.fetch_count !== 32'h0) $display("FAIL midreset_ifid got=%h/%0d exp=%h/0", fif.ifid_pc, fif.fetch_count, 32'h0); else n_pass++;
    endtask

    initial begin
        rst             = 1'b1;
        fif.stall       = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 32'h0;
        fif.halt        = 1'b0;
        m_state         = M_BOOT;
        m_pc            = 32'h0;
        m_count         = 32'h0;
        m_mis           = 1'b0;
        m_ifid_pc       = 32'h0;
        #1;
        test_reset();
        test_run();
        test_stall();
        test_redirect(32'h0000_0040);
        test_redirect(32'h0000_0042);
        test_wrap();
        test_back_to_back();
        test_halt();
        test_reset_overrides();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
